// File: rtl/uart_tx_arb_if.sv
// Requester-side byte handshake and TX FIFO write port of the UART transmit arbiter.
interface uart_tx_arb_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [3:0]  grant;
  logic        busy;
  logic        overlong_err;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_data, grant, busy, overlong_err
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_data, grant, busy, overlong_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets one of four requesters stream a whole message into the
// UART TX FIFO, releasing on the last byte or after MAX_BURST bytes.
module uart_tx_arb #(
  parameter int MAX_BURST = 16
) (
  input logic          clk,
  input logic          reset_n,
  uart_tx_arb_if.slave bus
);
  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_owner_q, last_owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       beat;

  // First valid requester after the previous owner, wrapping through all four.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_owner_d     = last_owner_q;
    cnt_d            = cnt_q;
    beat             = 1'b0;
    bus.req_ready    = 4'b0000;
    bus.fifo_wr      = 1'b0;
    bus.fifo_data    = 8'h00;
    bus.grant        = 4'b0000;
    bus.busy         = 1'b0;
    bus.overlong_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          owner_d = rr_pick(bus.req_valid, last_owner_q);
          cnt_d   = 8'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        bus.grant[owner_q] = 1'b1;
        bus.busy           = 1'b1;
        bus.fifo_data      = bus.req_data[{owner_q, 3'b000} +: 8];
        // Acceptance is suppressed during reset so an abandoned message gets no further beats.
        bus.req_ready[owner_q] = !bus.fifo_full && reset_n;
        beat        = bus.req_valid[owner_q] && !bus.fifo_full && reset_n;
        bus.fifo_wr = beat;
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          if (bus.req_last[owner_q]) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end else if (cnt_d == MAX_B) begin
            state_d          = IDLE;
            last_owner_d     = owner_q;
            bus.overlong_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (MAX_BURST=4) with hand-computed cycle-by-cycle expectations.
module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_tx_arb_if bus();

  uart_tx_arb #(.MAX_BURST(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Reset with all requesters valid; arbitration must not win over reset.
  task automatic do_reset(input string tag);
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h0;
    bus.req_last  = 4'h0;
    bus.fifo_full = 1'b0;
    reset_n       = 1'b0;
    @(posedge clk);
    #3;
    chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_wr"}, 32'(bus.fifo_wr), 32'h0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_ovl"}, 32'(bus.overlong_err), 32'h0);
    reset_n       = 1'b1;
    bus.req_valid = 4'h0;
  endtask

  // One requester r streams bytes 8'hA1+b; masks give per-cycle expectations (bit c = cycle c).
  task automatic run_single(input string tag, input int r, input int nbytes, input int last_idx,
                            input logic [15:0] full_m, input int ncyc, input logic [15:0] wr_m,
                            input logic [15:0] own_m, input logic [15:0] ovl_m);
    int b;
    logic [3:0] onehot;
    b = 0;
    onehot = 4'(1 << r);
    for (int c = 0; c < ncyc; c++) begin
      bus.req_valid = (b < nbytes) ? onehot : 4'h0;
      bus.req_data  = 32'hEEEE_EEEE;
      bus.req_data[8*r +: 8] = 8'hA1 + 8'(b);
      bus.req_last  = (b == last_idx) ? onehot : 4'h0;
      bus.fifo_full = full_m[c];
      #1;
      chk({tag, "_wr"}, 32'(bus.fifo_wr), 32'(wr_m[c]));
      chk({tag, "_grant"}, 32'(bus.grant), own_m[c] ? 32'(onehot) : 32'h0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'(own_m[c]));
      chk({tag, "_ovl"}, 32'(bus.overlong_err), 32'(ovl_m[c]));
      chk({tag, "_ready"}, 32'(bus.req_ready),
          (own_m[c] && !full_m[c]) ? 32'(onehot) : 32'h0);
      chk({tag, "_data"}, 32'(bus.fifo_data), own_m[c] ? 32'(8'hA1 + 8'(b)) : 32'h0);
      if (wr_m[c]) b++;
      next_cycle();
    end
  endtask

  initial begin
    int k[4];
    int nb;
    int exp_cyc[10];
    logic [3:0] v6[9];
    logic [3:0] g6[9];
    logic       w6[9];
    logic [7:0] d6[9];

    bus.req_valid = 4'h0;
    bus.req_data  = 32'h0;
    bus.req_last  = 4'h0;
    bus.fifo_full = 1'b0;

    // All four requesters, 2-byte messages: grants 0,1,2,3,0 with one IDLE cycle between.
    do_reset("r1");
    exp_cyc = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
    for (int i = 0; i < 4; i++) k[i] = 0;
    nb = 0;
    for (int c = 0; c < 16; c++) begin
      bus.req_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
        bus.req_data[8*i +: 8] = 8'(i * 16 + k[i]);
        bus.req_last[i]        = (k[i] == 1);
      end
      #1;
      if (bus.fifo_wr && nb < 10) begin
        chk("s1_grant", 32'(bus.grant), 32'(1 << ((nb / 2) % 4)));
        chk("s1_data", 32'(bus.fifo_data), 32'(((nb / 2) % 4) * 16 + nb % 2));
        chk("s1_cycle", 32'(c), 32'(exp_cyc[nb]));
        nb++;
      end
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) k[i] = k[i] ^ 1;
      next_cycle();
    end
    chk("s1_beats", 32'(nb), 32'd10);

    // Requester 2, three bytes, FIFO full for two cycles after the first.
    do_reset("r2");
    run_single("s2", 2, 3, 2, 16'b0000_1100, 7, 16'b0011_0010, 16'b0011_1110, 16'h0);

    // Requester 1, six bytes without last: forced release after 4, regrant after one IDLE.
    do_reset("r3");
    run_single("s3", 1, 6, -1, 16'h0, 8, 16'b1101_1110, 16'b1101_1110, 16'b0001_0000);

    // Requester 1, last on the 4th byte: normal release, no overlong_err.
    do_reset("r4");
    run_single("s4", 1, 4, 3, 16'h0, 6, 16'b0001_1110, 16'b0001_1110, 16'h0);

    // Reset mid-message; round-robin pointer returns to requester 0 first.
    do_reset("r5");
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0030;
    bus.req_last  = 4'b0001;
    next_cycle();
    #1;
    chk("s5_m0_wr", 32'(bus.fifo_wr), 32'h1);
    chk("s5_m0_grant", 32'(bus.grant), 32'h1);
    next_cycle();
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000_4100;
    bus.req_last  = 4'b0000;
    #1;
    chk("s5_idle_grant", 32'(bus.grant), 32'h0);
    next_cycle();
    #1;
    chk("s5_b1_wr", 32'(bus.fifo_wr), 32'h1);
    chk("s5_b1_data", 32'(bus.fifo_data), 32'h41);
    chk("s5_b1_grant", 32'(bus.grant), 32'h2);
    next_cycle();
    reset_n      = 1'b0;
    bus.req_data = 32'h0000_4200;
    #1;
    chk("s5_rst_wr", 32'(bus.fifo_wr), 32'h0);
    next_cycle();
    reset_n       = 1'b1;
    bus.req_valid = 4'b1001;
    bus.req_data  = 32'h5000_0050;
    bus.req_last  = 4'b1001;
    #1;
    chk("s5_post_grant", 32'(bus.grant), 32'h0);
    chk("s5_post_wr", 32'(bus.fifo_wr), 32'h0);
    chk("s5_post_ready", 32'(bus.req_ready), 32'h0);
    chk("s5_post_busy", 32'(bus.busy), 32'h0);
    chk("s5_post_data", 32'(bus.fifo_data), 32'h0);
    next_cycle();
    #1;
    chk("s5_rr_grant", 32'(bus.grant), 32'h1);
    chk("s5_rr_wr", 32'(bus.fifo_wr), 32'h1);
    chk("s5_rr_data", 32'(bus.fifo_data), 32'h50);

    // Owner 0 drops valid for three cycles while requester 1 waits.
    do_reset("r6");
    v6 = '{4'h3, 4'h3, 4'h2, 4'h2, 4'h2, 4'h3, 4'h2, 4'h2, 4'h0};
    g6 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0};
    w6 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d6 = '{8'h00, 8'h60, 8'h60, 8'h60, 8'h60, 8'h61, 8'h00, 8'h70, 8'h00};
    for (int c = 0; c < 9; c++) begin
      bus.req_valid = v6[c];
      bus.req_data  = {16'h0, 8'h70, (c < 5) ? 8'h60 : 8'h61};
      bus.req_last  = {2'b00, 1'b1, (c >= 5)};
      #1;
      chk("s6_grant", 32'(bus.grant), 32'(g6[c]));
      chk("s6_wr", 32'(bus.fifo_wr), 32'(w6[c]));
      chk("s6_data", 32'(bus.fifo_data), 32'(d6[c]));
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter: MAX_BURST, default 16, maximum bytes per grant before forced release (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  4  per-requester byte valid (bit i = requester i).
REQ-005 SHALL have port: req_data  input  32  per-requester byte; requester i on bits [8i+7:8i].
REQ-006 SHALL have port: req_last  input  4  per-requester last-byte-of-message marker, qualified by req_valid.
REQ-007 SHALL have port: req_ready  output  4  per-requester byte accepted when valid and ready are both high.
REQ-008 SHALL have port: fifo_full  input  1  TX FIFO full flag.
REQ-009 SHALL have port: fifo_wr  output  1  TX FIFO write strobe.
REQ-010 SHALL have port: fifo_data  output  8  TX FIFO write data.
REQ-011 SHALL have port: grant  output  4  one-hot current owner; all-zero when idle.
REQ-012 SHALL have port: busy  output  1  high while any requester holds the grant.
REQ-013 SHALL have port: overlong_err  output  1  one-cycle pulse on forced release at MAX_BURST.

Function
REQ-014 SHALL implement two states: IDLE and OWN.
REQ-015 IDLE: if any req_valid bit is high, SHALL select the winner round-robin, searching from (last_owner+1) mod 4 upward with wrap; register it into grant; enter OWN next cycle.
REQ-016 Arbitration latency SHALL be exactly one cycle: no byte is accepted in the cycle the request is first seen in IDLE.
REQ-017 In IDLE, req_ready, fifo_wr and grant SHALL all be 0, and fifo_data SHALL be 8'h00.
REQ-018 In OWN with owner g: req_ready[g] SHALL equal !fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-019 In OWN: fifo_wr SHALL equal req_valid[g] & !fifo_full; fifo_data SHALL equal requester g's byte; an accepted byte is a "beat".
REQ-020 fifo_full high SHALL stall the owner with no beat, no state change and no loss of grant.
REQ-021 An 8-bit beat counter SHALL clear on entry to OWN and increment on each beat.
REQ-022 A beat with req_last[g]=1 SHALL return to IDLE next cycle and record last_owner=g.
REQ-023 A beat that makes the count equal MAX_BURST without req_last SHALL return to IDLE, record last_owner=g, and pulse overlong_err for exactly that cycle.
REQ-024 When last and the MAX_BURST limit coincide on one beat, it SHALL be a normal release with no overlong_err.
REQ-025 Owner dropping req_valid mid-message SHALL NOT release the grant; only REQ-022 or REQ-023 release.
REQ-026 Non-owner req_valid changes during OWN SHALL have no effect on the current grant.
REQ-027 busy SHALL equal (state==OWN); grant SHALL be one-hot or zero at all times.

Reset
REQ-028 With reset_n low at a clock edge: state=IDLE, grant=0, busy=0, beat counter=0, overlong_err=0, last_owner=3 (requester 0 wins first), fifo_wr=0, req_ready=0.
REQ-029 Reset asserted mid-message SHALL abandon the message with no further beats; the partial message stays in the FIFO.

Verification
REQ-030 Bench SHALL cover: req_valid=4'b1111, each sending 2-byte messages -> grants in order 0,1,2,3,0; each message's two bytes appear contiguously in fifo_data.
REQ-031 Bench SHALL cover: requester 2 sends 3 bytes (A1,A2,A3 last) with fifo_full high for 2 cycles after A1 -> fifo_wr gaps exactly 2 cycles; output sequence A1,A2,A3; grant held throughout.
REQ-032 Bench SHALL cover: MAX_BURST=4, requester 1 sends 6 bytes with no last -> 4 beats, overlong_err pulses once on 4th beat, regrant (1 alone requesting) after one IDLE cycle.
REQ-033 Bench SHALL cover: MAX_BURST=4, last on 4th byte -> no overlong_err.
REQ-034 Bench SHALL cover: reset_n low for 1 cycle after 1st of 3 bytes -> all outputs 0 next cycle; after release with requesters 0 and 3 valid, requester 0 granted first.
REQ-035 Bench SHALL cover: owner 0 drops req_valid for 3 cycles mid-message while requester 1 is valid -> grant stays 4'b0001; requester 1 granted only after 0's last beat.
